// File: rtl/divsub_pkg.sv
// Shared definitions for the repeated-subtraction divider: FSM states and width default.
package divsub_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_B = 3'd1,
    CHECK  = 3'd2,
    SUB    = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/divsub_dp.sv
// Divider datapath: remainder/dividend register, divisor register, quotient counter,
// subtractor, >= comparator and divisor zero detect.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   data_in              shared operand bus
//   load_a               load dividend into remainder register
//   load_b               load divisor register
//   clear                zero the quotient and div_zero flag
//   dec / inc            remainder -= divisor / quotient += 1
//   set_dz               divide-by-zero result: quotient all-ones, div_zero set
//   quotient, remainder  result registers
//   div_zero             divide-by-zero flag register
//   rem_ge_div           remainder >= divisor (combinational status)
//   div_is_zero          divisor == 0 (combinational status)
module divsub_dp
  import divsub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             clear,
  input  logic             dec,
  input  logic             inc,
  input  logic             set_dz,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             rem_ge_div,
  output logic             div_is_zero
);

  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] quo_reg;
  logic             dz_reg;

  // Remainder register: holds the dividend, then shrinks by the divisor each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg <= '0;
    end else if (load_a) begin
      rem_reg <= data_in;
    end else if (dec) begin
      rem_reg <= rem_reg - div_reg;
    end
  end

  // Divisor register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
    end else if (load_b) begin
      div_reg <= data_in;
    end
  end

  // Quotient counter and divide-by-zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_reg <= '0;
      dz_reg  <= 1'b0;
    end else if (clear) begin
      quo_reg <= '0;
      dz_reg  <= 1'b0;
    end else if (set_dz) begin
      quo_reg <= '1;
      dz_reg  <= 1'b1;
    end else if (inc) begin
      quo_reg <= quo_reg + WIDTH'(1);
    end
  end

  assign rem_ge_div  = (rem_reg >= div_reg);
  assign div_is_zero = (div_reg == '0);
  assign quotient    = quo_reg;
  assign remainder   = rem_reg;
  assign div_zero    = dz_reg;

endmodule

// File: rtl/divsub_unit.sv
// Unsigned divider by repeated subtraction (one subtract-and-increment per cycle).
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                begin an operation (honoured only in IDLE or DONE)
//   data_in              dividend on the start cycle, divisor on the next cycle
//   quotient, remainder  results, valid while done=1
//   busy                 high in LOAD_B, CHECK, SUB
//   done                 high in DONE
//   div_zero             high in DONE when the divisor was zero
module divsub_unit
  import divsub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_t state_q;
  state_t state_d;

  logic load_a_c;
  logic load_b_c;
  logic clear_c;
  logic dec_c;
  logic inc_c;
  logic set_dz_c;
  logic rem_ge_div;
  logic div_is_zero;

  divsub_dp #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .load_a      (load_a_c),
    .load_b      (load_b_c),
    .clear       (clear_c),
    .dec         (dec_c),
    .inc         (inc_c),
    .set_dz      (set_dz_c),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_zero    (div_zero),
    .rem_ge_div  (rem_ge_div),
    .div_is_zero (div_is_zero)
  );

  // State register; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == LOAD_B) || (state_d == CHECK) || (state_d == SUB);
      done    <= (state_d == DONE);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    load_a_c = 1'b0;
    load_b_c = 1'b0;
    clear_c  = 1'b0;
    dec_c    = 1'b0;
    inc_c    = 1'b0;
    set_dz_c = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load_a_c = 1'b1;
          clear_c  = 1'b1;
          state_d  = LOAD_B;
        end
      end
      LOAD_B: begin
        load_b_c = 1'b1;
        state_d  = CHECK;
      end
      CHECK: begin
        if (div_is_zero) begin
          set_dz_c = 1'b1;
          state_d  = DONE;
        end else begin
          state_d  = SUB;
        end
      end
      SUB: begin
        if (rem_ge_div) begin
          dec_c = 1'b1;
          inc_c = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
